// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit with private HI/LO registers.
// A multiply or divide result is computed when the start is accepted and held in
// pHI/pLO. It is committed to HI/LO when the busy countdown expires.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_V1,
  input  logic [31:0] E_V2,
  input  logic [3:0]  E_MDUOp,
  input  logic        E_Start,
  output logic        E_Busy,
  output logic [31:0] E_MDUOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned DW         = 32;
  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_hi;
  logic [DW-1:0]    r_lo;
  logic [DW-1:0]    r_phi;
  logic [DW-1:0]    r_plo;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [DW-1:0]    w_hi_nxt;
  logic [DW-1:0]    w_lo_nxt;
  logic [DW-1:0]    w_phi_nxt;
  logic [DW-1:0]    w_plo_nxt;
  logic             w_busy_nxt;

  logic             w_is_mul;
  logic             w_is_div;
  logic             w_signed;
  logic             w_ext_a;
  logic             w_ext_b;
  logic [2*DW-1:0]  w_prod;
  logic [DW-1:0]    w_mag_a;
  logic [DW-1:0]    w_mag_b;
  logic             w_div_zero;
  logic [DW-1:0]    w_uquo;
  logic [DW-1:0]    w_urem;
  logic [DW-1:0]    w_quo;
  logic [DW-1:0]    w_rem;

  // Operation decode
  assign w_is_mul   = (E_MDUOp == OP_MULT) || (E_MDUOp == OP_MULTU);
  assign w_is_div   = (E_MDUOp == OP_DIV)  || (E_MDUOp == OP_DIVU);
  assign w_signed   = (E_MDUOp == OP_MULT) || (E_MDUOp == OP_DIV);

  // One 64-bit multiplier; signed products come from sign-extended operands
  assign w_ext_a    = w_signed & E_V1[DW-1];
  assign w_ext_b    = w_signed & E_V2[DW-1];
  assign w_prod     = {{DW{w_ext_a}}, E_V1} * {{DW{w_ext_b}}, E_V2};

  // Signed divide on magnitudes, so 0x80000000 / -1 cannot overflow the divider
  assign w_mag_a    = (w_signed && E_V1[DW-1]) ? (DW'(0) - E_V1) : E_V1;
  assign w_mag_b    = (w_signed && E_V2[DW-1]) ? (DW'(0) - E_V2) : E_V2;
  assign w_div_zero = (E_V2 == '0);
  assign w_uquo     = w_div_zero ? '0 : (w_mag_a / w_mag_b);
  assign w_urem     = w_div_zero ? '0 : (w_mag_a % w_mag_b);
  assign w_quo      = (w_signed && (E_V1[DW-1] ^ E_V2[DW-1])) ? (DW'(0) - w_uquo) : w_uquo;
  assign w_rem      = (w_signed && E_V1[DW-1]) ? (DW'(0) - w_urem) : w_urem;

  // State register and datapath registers; reset discards any pending result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_phi   <= '0;
      r_plo   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_phi   <= w_phi_nxt;
      r_plo   <= w_plo_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state logic: accept start/MTxx only in IDLE, count down and commit in RUN
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_phi_nxt   = r_phi;
    w_plo_nxt   = r_plo;
    w_busy_nxt  = r_busy;
    case (r_state)
      S_IDLE: begin
        if (E_Start && (w_is_mul || w_is_div)) begin
          w_state_nxt = S_RUN;
          w_busy_nxt  = 1'b1;
          if (w_is_mul) begin
            w_cnt_nxt = CNT_W'(MULT_CYCLES);
            w_phi_nxt = w_prod[2*DW-1:DW];
            w_plo_nxt = w_prod[DW-1:0];
          end else begin
            w_cnt_nxt = CNT_W'(DIV_CYCLES);
            if (w_div_zero) begin
              // Divide by zero leaves HI/LO untouched after the full busy period
              w_phi_nxt = r_hi;
              w_plo_nxt = r_lo;
            end else begin
              w_phi_nxt = w_rem;
              w_plo_nxt = w_quo;
            end
          end
        end else if (E_MDUOp == OP_MTHI) begin
          w_hi_nxt = E_V1;
        end else if (E_MDUOp == OP_MTLO) begin
          w_lo_nxt = E_V1;
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_hi_nxt    = r_phi;
          w_lo_nxt    = r_plo;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Combinational MFHI/MFLO read of the committed registers
  always_comb begin
    E_MDUOut = '0;
    case (E_MDUOp)
      OP_MFHI: E_MDUOut = r_hi;
      OP_MFLO: E_MDUOut = r_lo;
      default: E_MDUOut = '0;
    endcase
  end

  assign E_Busy = r_busy;
  assign HI     = r_hi;
  assign LO     = r_lo;

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It sits directly downstream of the D/E pipeline register. It consumes the forwarded E_V1/E_V2 operands and the decoded MDU opcode for the instruction in E. It performs multi-cycle MULT/MULTU/DIV/DIVU into private HI/LO registers and serves MFHI/MFLO/MTHI/MTLO. It exports a busy flag that the hazard unit combines with E_Start to stall D.

## Interface
- MULT_CYCLES, 5, cycles busy stays high after a multiply start (≥1)
- DIV_CYCLES, 10, cycles busy stays high after a divide start (≥1)

- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- E_V1  in  32  rs operand (post-forwarding)
- E_V2  in  32  rt operand (post-forwarding)
- E_MDUOp  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9–15 treated as NONE
- E_Start  in  1  high for one cycle with ops 1–4; ignored with any other op
- E_Busy  out  1  high while an operation is in flight
- E_MDUOut  out  32  HI when op=MFHI, LO when op=MFLO, else 0
- HI  out  32  current HI register (debug/bench visibility)
- LO  out  32  current LO register

## Operation
- State:
  - HI, LO: 32 bits each.
  - Counter cnt, wide enough for max(MULT_CYCLES, DIV_CYCLES).
  - Pending result regs pHI, pLO: 32 bits each.
  - E_Busy register.
- Two states:
  - IDLE (cnt=0, E_Busy=0).
  - RUN (cnt>0, E_Busy=1).
- IDLE, clock edge with E_Start=1 and op 1–4:
  - Compute the result from the E_V1/E_V2 values present at that edge.
  - Load pHI/pLO with the result.
  - Load cnt with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
  - Set E_Busy=1 and move to RUN.
- RUN, each edge:
  - cnt decrements.
  - On the edge where cnt==1: HI<=pHI, LO<=pLO, cnt<=0, E_Busy<=0, move to IDLE.
- Arithmetic:
  - MULT: {HI,LO} = signed(E_V1) × signed(E_V2), 64-bit.
  - MULTU: the same product, unsigned.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend, i.e. signed Verilog / and %.
  - DIVU: unsigned / and %.
- Divide by zero (E_V2==0, DIV or DIVU):
  - The full DIV_CYCLES busy period still runs.
  - At completion HI and LO keep their pre-start values (pHI/pLO are loaded with the current HI/LO).
- MTHI/MTLO:
  - In IDLE, write E_V1 into HI or LO at the clock edge.
  - Single cycle; E_Busy is not raised.
- MFHI/MFLO: E_MDUOut is a combinational read of the current HI/LO.
- Requests made while E_Busy=1 are ignored, with no state change: E_Start, MTHI and MTLO. The hazard unit guarantees they do not occur; the block still has to be safe if they do.
- During RUN, MFHI/MFLO return the old HI/LO.
- A pipeline bubble (opcode 0, E_Start=0) never disturbs an in-flight operation.

## Timing
- Reset values, also applied immediately on a reset assertion mid-RUN:
  - HI=0, LO=0, cnt=0, E_Busy=0.
  - E_MDUOut=0 unless op is MFHI/MFLO.
  - The pending result is discarded.
- Start sampled at edge t0. E_Busy is high in the cycles after edges t0 … t0+N−1, which is exactly N cycles.
- HI/LO take their new values at edge t0+N, the same edge E_Busy falls.
- The instruction following in E may issue a new E_Start in the first cycle with E_Busy=0. That makes back-to-back throughput one start per N+1 cycles.
- The hazard unit stalls D whenever (E_Start | E_Busy) and the instruction in D is an MDU op. E_Busy is registered and has no combinational path from inputs.
- MTHI/MTLO: HI/LO change at the edge ending the cycle the op is in E; visible next cycle.

## Test plan
- Reset, then MULT with E_V1=0xFFFFFFFF, E_V2=0x00000002 → E_Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU with the same operands → after 5 busy cycles, HI=0x00000001, LO=0xFFFFFFFE. MFHI in the next cycle → E_MDUOut=0x00000001.
- DIV with E_V1=0xFFFFFFF9 (−7), E_V2=0x00000002 → E_Busy high exactly 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
- MTHI 0x12345678, MTLO 0x9ABCDEF0 → no busy. DIVU 5/0 → 10 busy cycles, then HI=0x12345678, LO=0x9ABCDEF0 unchanged.
- DIV started, reset driven low at busy cycle 4 → E_Busy, HI and LO go to 0 without waiting for a clock edge. After release, no late write-back occurs.
- MULT started, E_Start with DIV and MTLO 0xFFFF0000 injected during busy → both ignored. Final HI/LO match the MULT result and busy length is 5.
